fetch_unit: RTL and testbench

// - Instruction fetch front end; produces the 32-bit instruction stream the decode stage consumes.
// - Owns the PC and issues sequential word requests to instruction memory.
// - Buffers in-order responses in a FIFO and presents them to decode with a valid/ready handshake.
// - Takes branch/jump redirects from execute and discards stale in-flight responses.

---
 rtl/fetch_unit.sv | 217 +++++++++++++++++++++
 tb/tb_fetch_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch front end.
//
// Owns the fetch PC and issues sequential word requests to instruction
// memory. In-order responses are buffered in a FIFO and handed to decode
// over a valid/ready handshake. Redirects from execute flush the buffer and
// discard responses that are still in flight.
//
// Optional feature macro: FETCH_MISALIGN_EN. When it is defined, a redirect to
// a non-word-aligned target parks the unit in a FAULT state and reports it on
// fetch_fault/fault_pc. When it is undefined, redirect_pc[1:0] is ignored.
//
// Parameters
//   RESET_PC    PC of the first fetch after reset
//   FIFO_DEPTH  instruction buffer entries (power of 2, >= 2); this is also
//               the cap on requests outstanding plus instructions buffered
//
// Ports
//   clk, rst_n         clock; synchronous active-low reset
//   imem_req_valid     request valid (registered)
//   imem_req_ready     memory accepts the request this cycle
//   imem_req_addr      word address of the request (the fetch PC)
//   imem_rsp_valid     in-order response valid
//   imem_rsp_data      instruction word
//   redirect_valid     branch/jump taken this cycle
//   redirect_pc        new fetch target
//   instr_valid        FIFO head valid for decode
//   instr_ready        decode consumes the head this cycle
//   instr, instr_pc    FIFO head instruction and its PC
//   fetch_fault        (FETCH_MISALIGN_EN only) misaligned redirect pending
//   fault_pc           (FETCH_MISALIGN_EN only) offending redirect target
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
`ifdef FETCH_MISALIGN_EN
  ,
  output logic        fetch_fault,
  output logic [31:0] fault_pc
`endif
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t DEPTH_C = cnt_t'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_FETCH,
    S_DISCARD
`ifdef FETCH_MISALIGN_EN
    ,
    S_FAULT
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  cnt_t        out_q, out_d;     // requests accepted, response not yet seen
  cnt_t        drop_q, drop_d;   // responses still to be discarded
  cnt_t        cnt_q, cnt_d;     // instruction FIFO occupancy
  ptr_t        rd_q, rd_d, wr_q, wr_d;
  ptr_t        tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
  logic        req_valid_q, req_valid_d;
  logic        instr_valid_q, instr_valid_d;

  logic [31:0] data_mem_q [FIFO_DEPTH];
  logic [31:0] dpc_mem_q  [FIFO_DEPTH];
  logic [31:0] tag_mem_q  [FIFO_DEPTH];  // PC of each outstanding request

  logic        do_accept, do_push, do_pop;

`ifdef FETCH_MISALIGN_EN
  logic [31:0] fault_pc_q, fault_pc_d;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    out_d     = out_q;
    drop_d    = drop_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    tag_rd_d  = tag_rd_q;
    tag_wr_d  = tag_wr_q;
    do_push   = 1'b0;
    do_pop    = 1'b0;
`ifdef FETCH_MISALIGN_EN
    fault_pc_d = fault_pc_q;
`endif

    do_accept = req_valid_q && imem_req_ready;
    if (do_accept) begin
      out_d    = out_d + 1'b1;
      tag_wr_d = tag_wr_q + 1'b1;
      pc_d     = pc_q + 32'd4;
    end

    // Every response retires a tag; it is buffered only when nothing is
    // pending discard.
    if (imem_rsp_valid) begin
      out_d    = out_d - 1'b1;
      tag_rd_d = tag_rd_q + 1'b1;
      if (drop_q != '0) begin
        drop_d = drop_q - 1'b1;
      end else begin
        do_push = 1'b1;
      end
    end

    if (redirect_valid) begin
      // Everything still in flight after this edge, including a request
      // accepted this cycle for the old PC, becomes stale.
      do_push = 1'b0;
      cnt_d   = '0;
      rd_d    = '0;
      wr_d    = '0;
      pc_d    = redirect_pc & 32'hFFFF_FFFC;
      drop_d  = out_d;
      state_d = (out_d != '0) ? S_DISCARD : S_FETCH;
`ifdef FETCH_MISALIGN_EN
      if (redirect_pc[1:0] != 2'b00) begin
        state_d    = S_FAULT;
        fault_pc_d = redirect_pc;
      end
`endif
    end else begin
      do_pop = instr_valid_q && instr_ready;
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      if (do_push && !do_pop) begin
        cnt_d = cnt_q + 1'b1;
      end else if (!do_push && do_pop) begin
        cnt_d = cnt_q - 1'b1;
      end
      if (state_q == S_DISCARD && drop_d == '0) begin
        state_d = S_FETCH;
      end
    end

    // Outputs are precomputed from next state so they leave on a register.
    req_valid_d   = (state_d == S_FETCH) && ((out_d + cnt_d) < DEPTH_C);
    instr_valid_d = (cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_FETCH;
      pc_q          <= RESET_PC;
      out_q         <= '0;
      drop_q        <= '0;
      cnt_q         <= '0;
      rd_q          <= '0;
      wr_q          <= '0;
      tag_rd_q      <= '0;
      tag_wr_q      <= '0;
      req_valid_q   <= 1'b0;
      instr_valid_q <= 1'b0;
      data_mem_q    <= '{default: '0};
      dpc_mem_q     <= '{default: '0};
      tag_mem_q     <= '{default: '0};
`ifdef FETCH_MISALIGN_EN
      fault_pc_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      out_q         <= out_d;
      drop_q        <= drop_d;
      cnt_q         <= cnt_d;
      rd_q          <= rd_d;
      wr_q          <= wr_d;
      tag_rd_q      <= tag_rd_d;
      tag_wr_q      <= tag_wr_d;
      req_valid_q   <= req_valid_d;
      instr_valid_q <= instr_valid_d;
      if (do_accept) begin
        tag_mem_q[tag_wr_q] <= pc_q;
      end
      if (do_push) begin
        data_mem_q[wr_q] <= imem_rsp_data;
        dpc_mem_q[wr_q]  <= tag_mem_q[tag_rd_q];
      end
`ifdef FETCH_MISALIGN_EN
      fault_pc_q    <= fault_pc_d;
`endif
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign instr_valid    = instr_valid_q;
  assign instr          = data_mem_q[rd_q];
  assign instr_pc       = dpc_mem_q[rd_q];

`ifdef FETCH_MISALIGN_EN
  assign fetch_fault = (state_q == S_FAULT);
  assign fault_pc    = fault_pc_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios followed by a randomized run,
// all checked against a transaction-level model of the fetch stream.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
`ifdef FETCH_MISALIGN_EN
  logic        fetch_fault;
  logic [31:0] fault_pc;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc)
`ifdef FETCH_MISALIGN_EN
    ,
    .fetch_fault   (fetch_fault),
    .fault_pc      (fault_pc)
`endif
  );

  // Memory request in flight; stale once a later redirect has superseded it.
  typedef struct {
    logic [31:0] addr;
    int unsigned due;
    bit          stale;
  } req_t;

  req_t        mq[$];
  logic [31:0] acc_log[$];
  int unsigned vectors = 0, miscompares = 0;
  int unsigned cyc = 0, last_due = 0, buffered = 0;
  int unsigned n_acc = 0, n_pop = 0;
  int unsigned lat_min = 1, lat_max = 1;
  bit          rdy_rand = 0, dec_rand = 0, dec_rdy = 1;
  bit          fault = 0, popped = 0;
  logic [31:0] exp_pc, exp_req_pc, exp_fault_pc, first_pop_pc;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  // Requests may issue only when nothing stale is pending, no fault is held,
  // and in-flight plus buffered work leaves room in the buffer.
  function automatic bit model_req_valid();
    bit any_stale = 0;
    foreach (mq[i]) if (mq[i].stale) any_stale = 1;
    return !fault && !any_stale && ((mq.size() + buffered) < DEPTH);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  // One clock cycle, entered and left at a negedge.
  task automatic cycle(input bit redir, input logic [31:0] tgt);
    bit          rv, acc, pp;
    req_t        r;
    int unsigned lat, due;
    logic [31:0] tgt_al;
    chk("req_valid", 32'(imem_req_valid), 32'(model_req_valid()));
    chk("instr_valid", 32'(instr_valid), 32'(buffered != 0));
`ifdef FETCH_MISALIGN_EN
    chk("fetch_fault", 32'(fetch_fault), 32'(fault));
    if (fault) chk("fault_pc", fault_pc, exp_fault_pc);
`endif
    rv = (mq.size() > 0) && (mq[0].due <= cyc);
    imem_rsp_valid = rv;
    imem_rsp_data  = rv ? memfn(mq[0].addr) : 32'hDEAD_BEEF;
    imem_req_ready = rdy_rand ? 1'($urandom_range(1, 0)) : 1'b1;
    instr_ready    = dec_rand ? 1'($urandom_range(1, 0)) : dec_rdy;
    redirect_valid = redir;
    redirect_pc    = tgt;
    acc = imem_req_valid && imem_req_ready;
    pp  = instr_valid && instr_ready && !redir;
    if (rv) begin
      r = mq.pop_front();
      if (!r.stale && !redir) buffered++;
    end
    if (acc) begin
      chk("req_addr", imem_req_addr, exp_req_pc);
      acc_log.push_back(imem_req_addr);
      n_acc++;
      lat = $urandom_range(lat_max, lat_min);
      due = cyc + lat;
      if (due < last_due) due = last_due;
      last_due = due;
      mq.push_back('{addr: imem_req_addr, due: due, stale: 1'b0});
      exp_req_pc = exp_req_pc + 32'd4;
    end
    if (pp) begin
      chk("instr_pc", instr_pc, exp_pc);
      chk("instr", instr, memfn(exp_pc));
      if (!popped) first_pop_pc = instr_pc;
      popped = 1;
      exp_pc = exp_pc + 32'd4;
      if (buffered > 0) buffered--;
      n_pop++;
    end
    if (redir) begin
      foreach (mq[i]) mq[i].stale = 1'b1;
      buffered = 0;
      tgt_al = tgt & 32'hFFFF_FFFC;
`ifdef FETCH_MISALIGN_EN
      fault = (tgt[1:0] != 2'b00);
      if (fault) exp_fault_pc = tgt;
`endif
      exp_pc     = tgt_al;
      exp_req_pc = tgt_al;
      acc_log.delete();
      popped = 0;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("rst_instr_valid", 32'(instr_valid), 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_req_addr", imem_req_addr, RESET_PC);
`ifdef FETCH_MISALIGN_EN
    chk("rst_fetch_fault", 32'(fetch_fault), 32'h0);
    chk("rst_fault_pc", fault_pc, 32'h0);
`endif
    mq.delete();
    acc_log.delete();
    buffered   = 0;
    last_due   = 0;
    exp_pc     = RESET_PC;
    exp_req_pc = RESET_PC;
    fault      = 0;
    popped     = 0;
    rst_n      = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int unsigned p0;

    do_reset();

    // Sequential fetch, memory always ready, latency 1, decode always ready.
    for (int k = 0; k < 10; k++) cycle(0, '0);
    p0 = n_pop;
    for (int k = 0; k < 10; k++) cycle(0, '0);
    chk("steady_rate", n_pop - p0, 32'd10);

    // Decode stalls: work in flight saturates at the buffer depth.
    dec_rdy = 0;
    for (int k = 0; k < 10; k++) cycle(0, '0);
    chk("stall_inflight", n_acc - n_pop, 32'(DEPTH));
    chk("stall_req_valid", 32'(imem_req_valid), 32'h0);
    dec_rdy = 1;
    for (int k = 0; k < 12; k++) cycle(0, '0);

    // Redirect with three requests in flight at latency 3.
    lat_min = 3; lat_max = 3;
    for (int k = 0; k < 20 && mq.size() != 3; k++) cycle(0, '0);
    chk("c_outstanding", 32'(mq.size()), 32'd3);
    cycle(1, 32'h0000_0100);
    for (int k = 0; k < 30 && !popped; k++) cycle(0, '0);
    chk("c_popped", 32'(popped), 32'h1);
    chk("c_first_pc", first_pop_pc, 32'h0000_0100);

    // Full buffer, redirect and pop together; then two redirects back to back.
    lat_min = 1; lat_max = 1;
    dec_rdy = 0;
    for (int k = 0; k < 10; k++) cycle(0, '0);
    chk("d_full_req_valid", 32'(imem_req_valid), 32'h0);
    chk("d_full_instr_valid", 32'(instr_valid), 32'h1);
    dec_rdy = 1;
    cycle(1, 32'h0000_0300);
    chk("d_flush", 32'(instr_valid), 32'h0);
    chk("d_target", imem_req_addr, 32'h0000_0300);
    lat_min = 3; lat_max = 3;
    cycle(0, '0);
    cycle(0, '0);
    cycle(1, 32'h0000_0400);
    cycle(1, 32'h0000_0500);
    chk("d_discard_idle", 32'(imem_req_valid), 32'h0);
    for (int k = 0; k < 30 && !popped; k++) cycle(0, '0);
    chk("d_popped", 32'(popped), 32'h1);
    chk("d_last_wins", first_pop_pc, 32'h0000_0500);

    // PC wraps past the top of the address space.
    lat_min = 1; lat_max = 1;
    cycle(1, 32'hFFFF_FFF8);
    for (int k = 0; k < 12; k++) cycle(0, '0);
    chk("e_nacc", 32'(acc_log.size() >= 3), 32'h1);
    if (acc_log.size() >= 3) begin
      chk("e_addr0", acc_log[0], 32'hFFFF_FFF8);
      chk("e_addr1", acc_log[1], 32'hFFFF_FFFC);
      chk("e_addr2", acc_log[2], 32'h0000_0000);
    end

`ifdef FETCH_MISALIGN_EN
    // Misaligned redirect faults; an aligned one resumes fetch.
    cycle(1, 32'h0000_0102);
    for (int k = 0; k < 5; k++) cycle(0, '0);
    chk("f_fault", 32'(fetch_fault), 32'h1);
    chk("f_fault_pc", fault_pc, 32'h0000_0102);
    chk("f_no_req", 32'(imem_req_valid), 32'h0);
    cycle(1, 32'h0000_0200);
    for (int k = 0; k < 20 && !popped; k++) cycle(0, '0);
    chk("f_cleared", 32'(fetch_fault), 32'h0);
    chk("f_first_pc", first_pop_pc, 32'h0000_0200);
`endif

    // Randomized traffic: memory stalls, variable latency, decode stalls,
    // random redirects (low bits random to exercise alignment handling).
    rdy_rand = 1; dec_rand = 1;
    lat_min = 1; lat_max = 4;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(19, 0) == 0) cycle(1, $urandom & 32'h0000_0FFF);
      else cycle(0, '0);
    end
    rdy_rand = 0; dec_rand = 0; dec_rdy = 1;

    // Reset mid-operation restarts from RESET_PC.
    for (int k = 0; k < 3; k++) cycle(0, '0);
    do_reset();
    lat_min = 1; lat_max = 1;
    for (int k = 0; k < 10 && !popped; k++) cycle(0, '0);
    chk("h_popped", 32'(popped), 32'h1);
    chk("h_first_pc", first_pop_pc, RESET_PC);
    for (int k = 0; k < 10; k++) cycle(0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
